// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } mem_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // r0 is hardwired zero, so it can never carry a dependency
    function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_count <= '0;
        else if (inc && (r_count != {W{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard unit: forwarding, load-use/branch stalls,
// data-memory wait FSM with timeout, and debug event counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         rsD,
    input  logic [4:0]         rtD,
    input  logic [4:0]         rsE,
    input  logic [4:0]         rtE,
    input  logic [4:0]         writeregE,
    input  logic [4:0]         writeregM,
    input  logic [4:0]         writeregW,
    input  logic               regwriteE,
    input  logic               regwriteM,
    input  logic               regwriteW,
    input  logic               memtoregE,
    input  logic               memtoregM,
    input  logic [1:0]         branchD,
    input  logic               memreqM,
    input  logic               mem_ready,
    output logic               stallF,
    output logic               stallD,
    output logic               stallE,
    output logic               stallM,
    output logic               flushE,
    output logic               flushW,
    output logic               forwardaD,
    output logic               forwardbD,
    output logic [1:0]         forwardaE,
    output logic [1:0]         forwardbE,
    output logic               mem_error,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] flush_count
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT) + 1;

    mem_state_t        r_state, w_next;
    logic [WCNT_W-1:0] r_wcnt;
    logic              w_memstall, w_lwstall, w_brstall, w_hz;

    always_comb begin
        forwardaE = FWD_RF;
        if (regwriteM && reg_hit(rsE, writeregM))      forwardaE = FWD_M;
        else if (regwriteW && reg_hit(rsE, writeregW)) forwardaE = FWD_W;

        forwardbE = FWD_RF;
        if (regwriteM && reg_hit(rtE, writeregM))      forwardbE = FWD_M;
        else if (regwriteW && reg_hit(rtE, writeregW)) forwardbE = FWD_W;
    end

    assign forwardaD = regwriteM && reg_hit(rsD, writeregM);
    assign forwardbD = regwriteM && reg_hit(rtD, writeregM);

    assign w_lwstall = memtoregE && (reg_hit(rsD, writeregE) || reg_hit(rtD, writeregE));
    assign w_brstall = (branchD != 2'd0) &&
                       ((regwriteE && (reg_hit(rsD, writeregE) || reg_hit(rtD, writeregE))) ||
                        (memtoregM && (reg_hit(rsD, writeregM) || reg_hit(rtD, writeregM))));
    assign w_hz      = w_lwstall || w_brstall;

    always_comb begin
        w_next     = r_state;
        w_memstall = 1'b0;
        case (r_state)
            IDLE: begin
                if (memreqM && !mem_ready) begin
                    w_next     = WAIT;
                    w_memstall = 1'b1;
                end
            end
            WAIT: begin
                // a late mem_ready still beats the timeout
                if (mem_ready) begin
                    w_next = IDLE;
                end else begin
                    w_memstall = 1'b1;
                    if (r_wcnt == WCNT_W'(MEM_TIMEOUT - 1))
                        w_next = ERROR;
                end
            end
            ERROR:   w_memstall = 1'b1;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_next;
            // held at zero outside WAIT so every WAIT entry starts from zero
            if (r_state == WAIT)
                r_wcnt <= r_wcnt + 1'b1;
            else
                r_wcnt <= '0;
        end
    end

    // memory stall freezes E, so no bubble there: the held instruction must survive
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        if (w_memstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (w_hz) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    assign mem_error = (r_state == ERROR);

    sat_counter #(.W(COUNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stallF),
        .count (stall_count)
    );

    sat_counter #(.W(COUNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flushE),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized scoreboard bench for hazard_unit against a rule-level reference model.
module tb_hazard_unit;

    localparam int MT = 4;
    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic       rwE, rwM, rwW, mtrE, mtrM;
        logic [1:0] br;
        logic       req, rdy;
    } stim_t;

    typedef struct {
        logic       sF, sD, sE, sM, fE, fW, faD, fbD, err;
        logic [1:0] faE, fbE;
        int         sc, fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memreqM, mem_ready;
    logic [1:0] branchD;
    logic stallF, stallD, stallE, stallM, flushE, flushW, forwardaD, forwardbD, mem_error;
    logic [1:0] forwardaE, forwardbE;
    logic [CW-1:0] stall_count, flush_count;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    // reference model state: plain flags and cycle counts
    bit m_err, m_inwait;
    int m_waited, m_sc, m_fc;

    always #5 clk = ~clk;

    hazard_unit #(.MEM_TIMEOUT(MT), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
        .memreqM(memreqM), .mem_ready(mem_ready),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushE(flushE), .flushW(flushW), .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE), .mem_error(mem_error),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    function automatic bit same(input logic [4:0] src, input logic [4:0] dst);
        return src != 0 && src == dst;
    endfunction

    function automatic logic [1:0] fwd_e(input stim_t s, input logic [4:0] src);
        if (s.rwM && same(src, s.wM)) return 2'b10;
        if (s.rwW && same(src, s.wW)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t model_out(input stim_t s);
        exp_t e;
        bit lw, brs, hz, ms;
        lw  = s.mtrE && (same(s.rsD, s.wE) || same(s.rtD, s.wE));
        brs = s.br != 0 && ((s.rwE && (same(s.rsD, s.wE) || same(s.rtD, s.wE))) ||
                            (s.mtrM && (same(s.rsD, s.wM) || same(s.rtD, s.wM))));
        hz  = lw || brs;
        ms  = m_err || (m_inwait ? !s.rdy : (s.req && !s.rdy));
        e.sF = ms || hz;  e.sD = ms || hz;
        e.sE = ms;        e.sM = ms;       e.fW = ms;
        e.fE = !ms && hz;
        e.faD = s.rwM && same(s.rsD, s.wM);
        e.fbD = s.rwM && same(s.rtD, s.wM);
        e.faE = fwd_e(s, s.rsE);
        e.fbE = fwd_e(s, s.rtE);
        e.err = m_err;
        e.sc = m_sc;  e.fc = m_fc;
        return e;
    endfunction

    task automatic model_step(input stim_t s, input exp_t e);
        if (e.sF && m_sc < CMAX) m_sc++;
        if (e.fE && m_fc < CMAX) m_fc++;
        if (m_err) return;
        if (!m_inwait) begin
            if (s.req && !s.rdy) begin m_inwait = 1; m_waited = 0; end
        end else if (s.rdy) begin
            m_inwait = 0;
        end else if (m_waited + 1 == MT) begin
            m_err = 1; m_inwait = 0;
        end else begin
            m_waited++;
        end
    endtask

    task automatic model_reset();
        m_err = 0; m_inwait = 0; m_waited = 0; m_sc = 0; m_fc = 0;
    endtask

    // entered just after a rising edge; returns just after the next one
    task automatic apply(input stim_t s, input bit rst);
        exp_t e;
        reset = !rst;
        if (rst) model_reset();
        rsD = s.rsD; rtD = s.rtD; rsE = s.rsE; rtE = s.rtE;
        writeregE = s.wE; writeregM = s.wM; writeregW = s.wW;
        regwriteE = s.rwE; regwriteM = s.rwM; regwriteW = s.rwW;
        memtoregE = s.mtrE; memtoregM = s.mtrM; branchD = s.br;
        memreqM = s.req; mem_ready = s.rdy;
        e = model_out(s);
        q.push_back(e);
        @(posedge clk);
        if (!rst) model_step(s, e);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", n, a, x, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stallF", 32'(stallF), 32'(e.sF));
            chk("stallD", 32'(stallD), 32'(e.sD));
            chk("stallE", 32'(stallE), 32'(e.sE));
            chk("stallM", 32'(stallM), 32'(e.sM));
            chk("flushE", 32'(flushE), 32'(e.fE));
            chk("flushW", 32'(flushW), 32'(e.fW));
            chk("forwardaD", 32'(forwardaD), 32'(e.faD));
            chk("forwardbD", 32'(forwardbD), 32'(e.fbD));
            chk("forwardaE", 32'(forwardaE), 32'(e.faE));
            chk("forwardbE", 32'(forwardbE), 32'(e.fbE));
            chk("mem_error", 32'(mem_error), 32'(e.err));
            chk("stall_count", 32'(stall_count), 32'(e.sc));
            chk("flush_count", 32'(flush_count), 32'(e.fc));
        end
    end

    initial begin
        stim_t s, z;
        z = '0;
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        apply(z, 1'b1);
        apply(z, 1'b0);
        // forwarding priority and r0 exclusion
        s = z; s.rsE = 3; s.wM = 3; s.rwM = 1; s.wW = 3; s.rwW = 1; s.rtE = 3;
        apply(s, 1'b0);
        s.rsE = 0; s.rwM = 0;
        apply(s, 1'b0);
        // load-use
        s = z; s.mtrE = 1; s.wE = 5; s.rsD = 5;
        apply(s, 1'b0);
        apply(z, 1'b0);
        // branch dependency on E ALU op, then M load, then resolved via forwarding
        s = z; s.br = 1; s.rtD = 7; s.rwE = 1; s.wE = 7;
        apply(s, 1'b0);
        s = z; s.br = 1; s.rtD = 7; s.mtrM = 1; s.wM = 7;
        apply(s, 1'b0);
        s.mtrM = 0; s.rwM = 1;
        apply(s, 1'b0);
        // three-cycle memory wait
        s = z; s.req = 1;
        repeat (3) apply(s, 1'b0);
        s.rdy = 1;
        apply(s, 1'b0);
        apply(z, 1'b0);
        // ready on the last allowed WAIT cycle beats the timeout
        s = z; s.req = 1;
        repeat (MT) apply(s, 1'b0);
        s.rdy = 1;
        apply(s, 1'b0);
        // timeout to ERROR with a load-use hazard held throughout
        apply(z, 1'b1);
        s = z; s.req = 1; s.mtrE = 1; s.wE = 9; s.rtD = 9;
        repeat (MT + 4) apply(s, 1'b0);
        s.req = 0; s.rdy = 1;
        repeat (2) apply(s, 1'b0);
        apply(z, 1'b1);
        // counter saturation
        s = z; s.mtrE = 1; s.wE = 2; s.rsD = 2;
        repeat (CMAX + 3) apply(s, 1'b0);
        apply(z, 1'b0);
        // random traffic over a narrow register range so matches are frequent
        repeat (3000) begin
            s.rsD = 5'($urandom_range(0, 3)); s.rtD = 5'($urandom_range(0, 3));
            s.rsE = 5'($urandom_range(0, 3)); s.rtE = 5'($urandom_range(0, 3));
            s.wE  = 5'($urandom_range(0, 3)); s.wM  = 5'($urandom_range(0, 3));
            s.wW  = 5'($urandom_range(0, 3));
            s.rwE = 1'($urandom); s.rwM = 1'($urandom); s.rwW = 1'($urandom);
            s.mtrE = 1'($urandom); s.mtrM = 1'($urandom);
            s.br  = ($urandom_range(0, 1) == 1) ? 2'($urandom) : 2'd0;
            s.req = ($urandom_range(0, 3) == 0);
            s.rdy = 1'($urandom);
            apply(s, $urandom_range(0, 39) == 0);
        end
        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
